// File: rtl/hex_report_tx.sv
// hex_report_tx: formats one SDRAM (address, data) record as ASCII hex and
// feeds it to a UART transmitter one character at a time.
// Optional feature macro: HEX_REPORT_ADDR_EN
//   defined   -> "AAAAAA:DDDD\r\n" (13 characters, address zero-extended to 24 bits)
//   undefined -> "DDDD\r\n"        (6 characters, req_addr unused, no address register)
// Parameter UPPER_HEX selects 'A'-'F' (1) or 'a'-'f' (0) for hex letters.
module hex_report_tx #(
    parameter int unsigned UPPER_HEX = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [20:0] req_addr,
    input  logic [15:0] req_data,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    input  logic        tx_done,
    output logic        busy
);

    localparam int unsigned ADDR_W = 21;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 4;
`ifdef HEX_REPORT_ADDR_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(12);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(5);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_data;
    logic                r_tx_dv;
    logic [7:0]          r_tx_byte;
    logic                r_req_ready;
    logic                r_busy;

    logic                w_is_idle;
    logic [IDX_W-1:0]    w_nxt_idx;
    logic [DATA_W-1:0]   w_src_data;
    logic [7:0]          w_char;

`ifdef HEX_REPORT_ADDR_EN
    logic [ADDR_W-1:0]   r_addr;
    logic [23:0]         w_src_addr;
`else
    logic                w_unused_addr;
    assign w_unused_addr = ^req_addr;
`endif

    // Nibble to ASCII hex digit
    function automatic logic [7:0] f_hex(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + 8'(n);
        end else if (UPPER_HEX != 0) begin
            return 8'h37 + 8'(n);
        end else begin
            return 8'h57 + 8'(n);
        end
    endfunction

    // Next character: from live inputs on accept, otherwise from the latched record
    always_comb begin
        w_is_idle  = (r_state == ST_IDLE);
        w_nxt_idx  = w_is_idle ? '0 : (r_idx + IDX_W'(1));
        w_src_data = w_is_idle ? req_data : r_data;
        w_char     = 8'h00;
`ifdef HEX_REPORT_ADDR_EN
        w_src_addr = {3'b000, (w_is_idle ? req_addr : r_addr)};
        case (w_nxt_idx)
            4'd0:    w_char = f_hex(w_src_addr[23:20]);
            4'd1:    w_char = f_hex(w_src_addr[19:16]);
            4'd2:    w_char = f_hex(w_src_addr[15:12]);
            4'd3:    w_char = f_hex(w_src_addr[11:8]);
            4'd4:    w_char = f_hex(w_src_addr[7:4]);
            4'd5:    w_char = f_hex(w_src_addr[3:0]);
            4'd6:    w_char = 8'h3A;
            4'd7:    w_char = f_hex(w_src_data[15:12]);
            4'd8:    w_char = f_hex(w_src_data[11:8]);
            4'd9:    w_char = f_hex(w_src_data[7:4]);
            4'd10:   w_char = f_hex(w_src_data[3:0]);
            4'd11:   w_char = 8'h0D;
            4'd12:   w_char = 8'h0A;
            default: w_char = 8'h00;
        endcase
`else
        case (w_nxt_idx)
            4'd0:    w_char = f_hex(w_src_data[15:12]);
            4'd1:    w_char = f_hex(w_src_data[11:8]);
            4'd2:    w_char = f_hex(w_src_data[7:4]);
            4'd3:    w_char = f_hex(w_src_data[3:0]);
            4'd4:    w_char = 8'h0D;
            4'd5:    w_char = 8'h0A;
            default: w_char = 8'h00;
        endcase
`endif
    end

    // Record FSM: IDLE accepts, SEND strobes one character, WAIT holds for tx_done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_data      <= '0;
            r_tx_dv     <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
`ifdef HEX_REPORT_ADDR_EN
            r_addr      <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_state     <= ST_SEND;
                        r_idx       <= '0;
                        r_data      <= req_data;
`ifdef HEX_REPORT_ADDR_EN
                        r_addr      <= req_addr;
`endif
                        r_tx_dv     <= 1'b1;
                        r_tx_byte   <= w_char;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_SEND: begin
                    r_tx_dv <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (r_idx == LAST_IDX) begin
                            r_state     <= ST_IDLE;
                            r_req_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_idx     <= w_nxt_idx;
                            r_state   <= ST_SEND;
                            r_tx_dv   <= 1'b1;
                            r_tx_byte <= w_char;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_tx_dv     <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign tx_dv     = r_tx_dv;
    assign tx_byte   = r_tx_byte;

endmodule

// File: tb/tb_hex_report_tx.sv
// Directed bench for hex_report_tx: an uppercase and a lowercase instance run
// in lockstep from shared stimulus; a fixed-latency UART reply (tx_done three
// cycles after each tx_dv) is produced inline by the stimulus sequence.
module tb_hex_report_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [20:0] req_addr;
    logic [15:0] req_data;
    logic        tx_done;

    logic        req_ready, busy, tx_dv;
    logic [7:0]  tx_byte;
    logic        lo_req_ready, lo_busy, lo_tx_dv;
    logic [7:0]  lo_tx_byte;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hex_report_tx #(.UPPER_HEX(1)) u_dut_up (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .tx_done   (tx_done),
        .busy      (busy)
    );

    hex_report_tx #(.UPPER_HEX(0)) u_dut_lo (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (lo_req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .tx_dv     (lo_tx_dv),
        .tx_byte   (lo_tx_byte),
        .tx_done   (tx_done),
        .busy      (lo_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check one record, entered in the cycle that should carry the first tx_dv.
    // stop_at > 0 pulls reset low right after that character's tx_dv and returns.
    task automatic emit(input string bu, input string bl, input int stop_at, input bit tog_addr);
        int n;
        logic [7:0] eu, el;
        n = bu.len() + 2;
        for (int i = 0; i < n; i++) begin
            if (i < bu.len()) begin
                eu = bu[i];
                el = bl[i];
            end else if (i == bu.len()) begin
                eu = 8'h0D;
                el = 8'h0D;
            end else begin
                eu = 8'h0A;
                el = 8'h0A;
            end
            chk($sformatf("%s[%0d] tx_dv", bu, i), 32'(tx_dv), 32'd1);
            chk($sformatf("%s[%0d] tx_byte", bu, i), 32'(tx_byte), 32'(eu));
            chk($sformatf("%s[%0d] lo_tx_byte", bl, i), 32'(lo_tx_byte), 32'(el));
            chk($sformatf("%s[%0d] busy", bu, i), 32'(busy), 32'd1);
            if (stop_at > 0 && i == stop_at - 1) begin
                #2 rst = 1'b0;
                #1;
                chk("abort tx_dv", 32'(tx_dv), 32'd0);
                chk("abort req_ready", 32'(req_ready), 32'd1);
                chk("abort busy", 32'(busy), 32'd0);
                chk("abort tx_byte", 32'(tx_byte), 32'h00);
                return;
            end
            if (tog_addr) req_addr = req_addr ^ 21'h15A5A5;
            tick();
            chk($sformatf("%s[%0d] dv_width", bu, i), 32'(tx_dv), 32'd0);
            chk($sformatf("%s[%0d] byte_hold", bu, i), 32'(tx_byte), 32'(eu));
            tick();
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            if (i == n - 1) begin
                chk($sformatf("%s ready_rise", bu), 32'(req_ready), 32'd1);
                chk($sformatf("%s busy_fall", bu), 32'(busy), 32'd0);
                chk($sformatf("%s no_extra_dv", bu), 32'(tx_dv), 32'd0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string b1u, b1l, b2u, b2l, b3u, b3l, b4u, b4l, b5u, b5l, b6u, b6l;
`ifdef HEX_REPORT_ADDR_EN
        b1u = "1ABCDE:BEEF"; b1l = "1abcde:beef";
        b2u = "000000:A5F0"; b2l = "000000:a5f0";
        b3u = "1FFFFF:0123"; b3l = "1fffff:0123";
        b4u = "054321:9C4D"; b4l = "054321:9c4d";
        b5u = "0F00D5:7E81"; b5l = "0f00d5:7e81";
        b6u = "100000:3C6A"; b6l = "100000:3c6a";
`else
        b1u = "BEEF"; b1l = "beef";
        b2u = "A5F0"; b2l = "a5f0";
        b3u = "0123"; b3l = "0123";
        b4u = "9C4D"; b4l = "9c4d";
        b5u = "7E81"; b5l = "7e81";
        b6u = "3C6A"; b6l = "3c6a";
`endif
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        tx_done   = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset tx_dv", 32'(tx_dv), 32'd0);
        chk("reset tx_byte", 32'(tx_byte), 32'h00);
        tick();
        tick();
        rst = 1'b1;

        // Record 1: accepted on the first edge after reset release; address toggles afterwards
        req_addr  = 21'h1ABCDE;
        req_data  = 16'hBEEF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        emit(b1u, b1l, 0, 1'b1);
        tick();

        // Record 2: all-zero address, mixed digits/letters in data
        req_addr  = 21'h000000;
        req_data  = 16'hA5F0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        emit(b2u, b2l, 0, 1'b0);
        tick();

        // Record 3: maximum address; req_valid stays high with new values while busy
        req_addr  = 21'h1FFFFF;
        req_data  = 16'h0123;
        req_valid = 1'b1;
        tick();
        req_addr  = 21'h054321;
        req_data  = 16'h9C4D;
        emit(b3u, b3l, 0, 1'b0);
        // Held request is accepted on the first IDLE edge, tx_dv the cycle after
        tick();
        req_valid = 1'b0;
        emit(b4u, b4l, 0, 1'b0);

        // tx_done while idle must not start anything
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("idle tx_done dv0", 32'(tx_dv), 32'd0);
        tick();
        chk("idle tx_done dv1", 32'(tx_dv), 32'd0);
        chk("idle tx_done ready", 32'(req_ready), 32'd1);

        // Record 5: aborted by reset after its 5th character
        req_addr  = 21'h0F00D5;
        req_data  = 16'h7E81;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        emit(b5u, b5l, 5, 1'b0);
        tick();
        chk("in-reset tx_dv", 32'(tx_dv), 32'd0);
        tick();
        rst = 1'b1;

        // Record 6: first edge after release accepts, sent from its first character
        req_addr  = 21'h100000;
        req_data  = 16'h3C6A;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        emit(b6u, b6l, 0, 1'b0);
        tick();
        chk("final dv", 32'(tx_dv), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hex_report_tx.md
HEX_REPORT_TX -- requirements
Module: hex_report_tx

Interface
REQ-001 SHALL have parameter UPPER_HEX, default 1, meaning: 1 = hex letters 'A'-'F', 0 = 'a'-'f'.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  record available.
REQ-005 SHALL have port req_ready  output  1  block idle and able to accept a record.
REQ-006 SHALL have port req_addr  input  21  SDRAM byte address to report.
REQ-007 SHALL have port req_data  input  16  SDRAM data word to report.
REQ-008 SHALL have port tx_dv  output  1  one-cycle strobe to UART transmitter.
REQ-009 SHALL have port tx_byte  output  8  ASCII character for the UART transmitter.
REQ-010 SHALL have port tx_done  input  1  one-cycle UART "byte finished" pulse.
REQ-011 SHALL have port busy  output  1  record in progress (equals ~req_ready).

Function
REQ-012 SHALL accept a record on a clk edge where req_valid=1 and req_ready=1, latching req_addr and req_data; later input changes SHALL NOT affect the record.
REQ-013 SHALL implement FSM states IDLE, SEND, WAIT: IDLE->SEND on accept; SEND->WAIT unconditionally after one cycle; WAIT->SEND on tx_done if characters remain; WAIT->IDLE on tx_done after the last character.
REQ-014 SHALL drive tx_dv=1 for exactly one cycle, only in SEND; tx_byte SHALL be valid in SEND and held stable until the next SEND.
REQ-015 SHALL emit the first tx_dv in the cycle after accept (latency 1); each later tx_dv SHALL occur in the cycle after the previous character's tx_done.
REQ-016 SHALL drive req_ready=1 only in IDLE; req_ready SHALL rise in the cycle after the final tx_done.
REQ-017 SHALL emit the record as: address as 6 hex digits, MSB first, with the 21-bit address zero-extended to 24 bits; then ':' (0x3A); then data as 4 hex digits, MSB first; then CR (0x0D); then LF (0x0A). Total 13 characters.
REQ-018 SHALL encode nibble 0-9 as 0x30-0x39, and 10-15 as 0x41-0x46 (UPPER_HEX=1) or 0x61-0x66 (UPPER_HEX=0).
REQ-019 SHALL use a 4-bit character index counter, reset to 0 on each accept, incremented on each tx_done in WAIT, with no wrap beyond the last index.
REQ-020 SHALL ignore tx_done in IDLE and SEND.
REQ-021 SHALL ignore req_valid while busy; no request queuing.
REQ-022 SHALL NOT change the accepted record when req_valid is asserted in the same cycle as the final tx_done; that request is accepted only on a later IDLE edge.

Reset
REQ-023 SHALL, while rst=0, force state IDLE, tx_dv=0, tx_byte=0x00, req_ready=1, busy=0, index=0, and clear the latched address and data, independent of clk.
REQ-024 SHALL, on reset asserted mid-record, drop tx_dv immediately and discard the record; after reset release, no character of the aborted record SHALL be sent.
REQ-025 SHALL, on reset release, be able to accept a record on the first clk edge with rst=1.

Configuration
REQ-026 SHALL include the address field and ':' (13-character record) only when macro HEX_REPORT_ADDR_EN is defined.
REQ-027 SHALL, without HEX_REPORT_ADDR_EN, emit only 4 data digits + CR + LF (6 characters); req_addr SHALL be unused and no address register SHALL be built.

Verification
REQ-028 SHALL cover: macro on, addr=0x1ABCDE, data=0xBEEF, UART model answering tx_done 3 cycles after each tx_dv -> bytes "1ABCDE:BEEF\r\n" in order; req_ready returns 1 one cycle after the 13th tx_done.
REQ-029 SHALL cover: UPPER_HEX=0, addr=0x000000, data=0xa5f0 -> "000000:a5f0\r\n"; addr=0x1FFFFF -> address field "1FFFFF" (or "1fffff").
REQ-030 SHALL cover: second req_valid held high during a record, and tx_done pulsed while IDLE -> no extra tx_dv; second record starts exactly 2 cycles after the final tx_done of the first (first IDLE edge accepts, tx_dv the following cycle).
REQ-031 SHALL cover: rst pulled low after the 5th character's tx_dv -> tx_dv=0 and req_ready=1 without a clk edge; after release, the next record is sent in full from its first character.
REQ-032 SHALL cover: macro off, data=0x0123 -> exactly 6 bytes "0123\r\n"; req_addr toggling has no effect on output.
